// File: rtl/text_fetch_sequencer.sv
// text_fetch_sequencer
// Pixel-rate sequencer between the VGA timing generator and the color mapper.
// Turns the scan position into the per-pixel operands the mapper needs:
// the character word from VRAM, the glyph row from the font ROM, the fg/bg
// colors from the palette, and the inverse flag. It is a fixed 3-stage pipeline,
// and it also owns the frame-counted cursor blink.
//
// Ports:
//   pixel_clk, reset          single clock; synchronous active-high reset
//   DrawX, DrawY              scan position (stage 0)
//   hsync_in, vsync_in        active-low syncs
//   blank_in                  1 = active video
//   vram_addr / vram_rdata    VRAM word port (address from stage 0, 1-cycle read)
//   font_addr / font_data     font ROM {code, row} (address from stage 1, 1-cycle read)
//   pal_fg_idx / pal_bg_idx   palette indices (stage 1)
//   pal_fg / pal_bg           palette colors, valid 1 cycle after the indices
//   cursor_en/_x/_y           cursor control, sampled in stage 0
//   DrawX_out, *sync_out,
//   blank_out                 sideband delayed 3 cycles
//   inv_bit, cmd, font_line   per-pixel operands for the color mapper
module text_fetch_sequencer #(
  parameter int BLINK_FRAMES = 30,
  parameter int COLS         = 80
) (
  input  logic        pixel_clk,
  input  logic        reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        blank_in,
  output logic [10:0] vram_addr,
  input  logic [31:0] vram_rdata,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  output logic [3:0]  pal_fg_idx,
  output logic [3:0]  pal_bg_idx,
  input  logic [11:0] pal_fg,
  input  logic [11:0] pal_bg,
  input  logic        cursor_en,
  input  logic [6:0]  cursor_x,
  input  logic [4:0]  cursor_y,
  output logic [9:0]  DrawX_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        blank_out,
  output logic        inv_bit,
  output logic [31:0] cmd,
  output logic [7:0]  font_line
);

  localparam int ROWS = 30;
  localparam int FCW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // Stage 0: character index, VRAM address, cursor hit
  logic [11:0] ci;
  logic        hit0;

  always_comb begin
    ci        = 12'(DrawY[9:4] * COLS) + 12'(DrawX[9:3]);
    vram_addr = blank_in ? ci[11:1] : '0;
    // The grid bounds stop a cursor parked off-screen from matching the
    // out-of-range DrawX/DrawY values seen during blanking.
    hit0 = cursor_en
        && (DrawX[9:3] == cursor_x) && (DrawY[8:4] == cursor_y)
        && ({25'd0, cursor_x} < COLS) && (cursor_y < 5'(ROWS));
  end

  logic       s1_half, s1_hit, s1_hs, s1_vs, s1_blank;
  logic [3:0] s1_row;
  logic [9:0] s1_x;

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      s1_half  <= 1'b0;
      s1_hit   <= 1'b0;
      s1_hs    <= 1'b0;
      s1_vs    <= 1'b0;
      s1_blank <= 1'b0;
      s1_row   <= '0;
      s1_x     <= '0;
    end else begin
      s1_half  <= ci[0];
      s1_hit   <= hit0;
      s1_hs    <= hsync_in;
      s1_vs    <= vsync_in;
      s1_blank <= blank_in;
      s1_row   <= DrawY[3:0];
      s1_x     <= DrawX;
    end
  end

  // Frame counter and blink phase
  logic           vs_prev;
  logic [FCW-1:0] frame_cnt;
  logic           blink_phase;

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      vs_prev     <= 1'b1;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      vs_prev <= vsync_in;
      if (vs_prev && !vsync_in) begin
        if (frame_cnt == FCW'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  // Stage 1: character select, font/palette addressing, inverse flag
  logic [15:0] chr;

  always_comb begin
    chr        = s1_half ? vram_rdata[31:16] : vram_rdata[15:0];
    font_addr  = {chr[14:8], s1_row};
    pal_fg_idx = chr[7:4];
    pal_bg_idx = chr[3:0];
  end

  logic       s2_inv, s2_hs, s2_vs, s2_blank;
  logic [9:0] s2_x;

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      s2_inv   <= 1'b0;
      s2_hs    <= 1'b0;
      s2_vs    <= 1'b0;
      s2_blank <= 1'b0;
      s2_x     <= '0;
    end else begin
      s2_inv   <= chr[15] ^ (s1_hit & blink_phase);
      s2_hs    <= s1_hs;
      s2_vs    <= s1_vs;
      s2_blank <= s1_blank;
      s2_x     <= s1_x;
    end
  end

  // Stage 2: capture ROM/palette data into the outputs, masked by blank
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      DrawX_out <= '0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      blank_out <= 1'b0;
      inv_bit   <= 1'b0;
      cmd       <= '0;
      font_line <= '0;
    end else begin
      DrawX_out <= s2_x;
      hsync_out <= s2_hs;
      vsync_out <= s2_vs;
      blank_out <= s2_blank;
      inv_bit   <= s2_blank & s2_inv;
      cmd       <= s2_blank ? {7'd0, pal_fg, pal_bg, 1'b0} : '0;
      font_line <= s2_blank ? font_data : '0;
    end
  end

endmodule

// File: doc/text_fetch_sequencer.md
# text_fetch_sequencer

Pixel-rate sequencer that turns the scan position into the per-pixel operands consumed by the color mapper: character word from VRAM, glyph row from font ROM, fg/bg colors from the palette, and the inverse flag. It sits between the VGA timing generator and the color mapper inside the HDMI text controller. It is a fixed 3-stage pipeline. Sync, blank and DrawX are delayed to match the pipeline. It also owns the frame-counted cursor blink.

## Interface
- `BLINK_FRAMES`, default 30: number of frames per cursor blink half-period.
- `COLS`, default 80: number of character columns.
- `pixel_clk` in 1: pixel clock, the single clock.
- `reset` in 1: synchronous, active-high reset.
- `DrawX`, `DrawY` in 10 each: current scan position.
- `hsync_in`, `vsync_in` in 1 each: active-low syncs.
- `blank_in` in 1: 1 = active video.
- `vram_addr` out 11: BRAM word address. Combinational from stage 0.
- `vram_rdata` in 32: BRAM data. Registered read, 1-cycle latency.
- `font_addr` out 11: font ROM address `{code[6:0], row[3:0]}`. Combinational from stage 1.
- `font_data` in 8: font ROM row. 1-cycle latency.
- `pal_fg_idx`, `pal_bg_idx` out 4 each: palette indices. Driven from stage 1.
- `pal_fg`, `pal_bg` in 12 each: palette colors `{r,g,b}`, 4 bits each. Registered lookup, valid 1 cycle after the index.
- `cursor_en` in 1: cursor enable.
- `cursor_x` in 7: cursor column.
- `cursor_y` in 5: cursor row.
- `DrawX_out` out 10: DrawX delayed 3 cycles.
- `hsync_out`, `vsync_out`, `blank_out` out 1 each: inputs delayed 3 cycles.
- `inv_bit` out 1: inverse flag to the color mapper.
- `cmd` out 32: colors to the color mapper. `cmd[24:13]` = fg, `cmd[12:1]` = bg, all other bits 0.
- `font_line` out 8: glyph row to the color mapper.

## Operation
- Character index: `ci = DrawY[9:4]*COLS + DrawX[9:3]`, 12 bits, range 0..2399.
- VRAM word: `vram_addr = ci[11:1]`. Each word holds 2 characters.
  - `ci[0]=0` selects bits [15:0]. `ci[0]=1` selects bits [31:16].
  - Character field layout: [15] inv, [14:8] code, [7:4] fg idx, [3:0] bg idx.
- Stage 0 (cycle t), from DrawX/DrawY:
  - Drive `vram_addr`. It is 0 when `blank_in=0`.
  - Register `ci[0]`, `DrawY[3:0]`, the cursor-hit flag, DrawX, syncs and blank into stage 1.
- Stage 1 (t+1):
  - Select the character half of `vram_rdata`.
  - Drive `font_addr`, `pal_fg_idx` and `pal_bg_idx` from it.
  - Register `inv ^ (cursor_hit & blink_phase & cursor_en)` and the sideband into stage 2.
- Stage 2 (t+2): `font_data`, `pal_fg` and `pal_bg` are valid. Register them into the outputs at the t+3 clock edge.
- Cursor hit: `DrawX[9:3]==cursor_x && DrawY[8:4]==cursor_y`, evaluated in stage 0.
  - A cursor position outside the 80x30 grid never hits.
- Blink:
  - `frame_cnt` counts falling edges of `vsync_in`, detected against the previous-cycle `vsync_in`.
  - `frame_cnt` wraps at `BLINK_FRAMES-1` back to 0. At each wrap, `blink_phase` toggles.
  - The cursor shows (inverted cell) when `blink_phase=1`.
- Blanking: when the stage-2 blank is 0, outputs are `cmd=0`, `font_line=0` and `inv_bit=0`. The delayed syncs still pass through.
- Out-of-range DrawX≥640 or DrawY≥480 arrives with `blank_in=0` and is handled by the blanking rule. No address wrap is required.

## Timing
- Latency from DrawX/DrawY/sync inputs to all outputs is exactly 3 `pixel_clk` cycles. One pixel is accepted per cycle, with no stalls.
- `DrawX_out` is delayed the same as `font_line`, so the color mapper indexes bit `7-DrawX_out[2:0]`.
- The cursor inputs are sampled in stage 0. A cursor change mid-character affects only pixels sampled after the change.
- Reset values:
  - All outputs 0, including `hsync_out` and `vsync_out`.
  - All pipeline registers 0.
  - `frame_cnt=0`, `blink_phase=0`.
  - The previous-vsync register is 1, so there is no false edge after reset.
- Reset mid-frame: the pipeline flushes. The first valid outputs appear 3 cycles after reset deasserts.
- A vsync falling edge on the same cycle as reset deassertion is ignored.

## Test plan
- Word 0 = `0x8041_0F12`, DrawX=0..15, DrawY=2:
  - Pixels 0–7 give `font_addr={0x0F? code 0x0F... low half code 0x0F,row 2}`, i.e. code `0x0F`, row 2. `inv_bit=0`, fg idx 1, bg idx 2.
  - Pixels 8–15 give code `0x00`, `inv_bit=1`, fg idx 4, bg idx 1.
  - Every output appears exactly 3 cycles after its input.
- Palette fg=`0xF00`, bg=`0x00F` → `cmd=0x01E0_001E`. With blank=0, `cmd=0` and `font_line=0`.
- DrawX=639, DrawY=479 → `vram_addr=1199`, upper half.
- `BLINK_FRAMES=2`, cursor (3,1), `cursor_en=1`, character inv=0:
  - `inv_bit=1` for cell (3,1) during frames 2–3.
  - `inv_bit=0` during frames 0–1 and 4–5.
  - Neighbouring cells are never inverted.
- Assert reset mid-line → next cycle all outputs are 0. `frame_cnt` and `blink_phase` clear. Syncs resume 3 cycles after release.
- `cursor_x=100` with `cursor_en=1` → no cell is ever inverted.
